// File: rtl/uart_bus_bridge.sv
// rtl/uart_bus_bridge.sv - UART command-frame parser acting as a single-word memory-bus initiator
// Parses R/W frames from the receive byte stream, runs one bus cycle, streams back status/data.
module uart_bus_bridge #(
  parameter int BUS_TIMEOUT   = 1024,
  parameter int FRAME_TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid_in,
  input  logic [7:0]  rx_data_in,
  output logic        tx_valid_out,
  output logic [7:0]  tx_data_out,
  input  logic        tx_ready_in,
  output logic [31:0] address_out,
  output logic        read_out,
  output logic        write_out,
  output logic [3:0]  write_mask_out,
  output logic [31:0] write_value_out,
  input  logic [31:0] read_value_in,
  input  logic        ready_in,
  input  logic        fault_in,
  output logic        overrun_out
);

  localparam int BW = $clog2(BUS_TIMEOUT + 1);
  localparam int FW = $clog2(FRAME_TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_MASK, S_DATA, S_BUS, S_RESP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [31:2]   addr_q, addr_d;
  logic [3:0]    mask_q, mask_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          is_write_q, is_write_d;
  logic          read_q, read_d;
  logic          write_q, write_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [2:0]    tx_left_q, tx_left_d;
  logic [BW-1:0] bus_cnt_q, bus_cnt_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          overrun_q, overrun_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      addr_q      <= '0;
      mask_q      <= '0;
      wdata_q     <= '0;
      is_write_q  <= 1'b0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      rdata_q     <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      tx_left_q   <= '0;
      bus_cnt_q   <= '0;
      frame_cnt_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      mask_q      <= mask_d;
      wdata_q     <= wdata_d;
      is_write_q  <= is_write_d;
      read_q      <= read_d;
      write_q     <= write_d;
      rdata_q     <= rdata_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      tx_left_q   <= tx_left_d;
      bus_cnt_q   <= bus_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    mask_d      = mask_q;
    wdata_d     = wdata_q;
    is_write_d  = is_write_q;
    read_d      = read_q;
    write_d     = write_q;
    rdata_d     = rdata_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    tx_left_d   = tx_left_q;
    bus_cnt_d   = bus_cnt_q;
    frame_cnt_d = frame_cnt_q;
    overrun_d   = overrun_q;
    case (state_q)
      S_IDLE: begin
        if (rx_valid_in) begin
          if (rx_data_in == 8'h52 || rx_data_in == 8'h57) begin
            state_d     = S_ADDR;
            is_write_d  = (rx_data_in == 8'h57);
            idx_d       = '0;
            frame_cnt_d = '0;
            overrun_d   = 1'b0;
          end else begin
            state_d    = S_RESP;
            tx_valid_d = 1'b1;
            tx_data_d  = 8'h02;
            tx_left_d  = '0;
          end
        end
      end
      S_ADDR, S_MASK, S_DATA: begin
        if (rx_valid_in) begin
          frame_cnt_d = '0;
          if (state_q == S_MASK) begin
            mask_d  = rx_data_in[3:0];
            state_d = S_DATA;
          end else begin
            idx_d = idx_q + 2'd1;
            if (state_q == S_ADDR) begin
              case (idx_q)
                2'd0:    addr_d[7:2]   = rx_data_in[7:2];
                2'd1:    addr_d[15:8]  = rx_data_in;
                2'd2:    addr_d[23:16] = rx_data_in;
                default: addr_d[31:24] = rx_data_in;
              endcase
            end else begin
              wdata_d[{idx_q, 3'b000} +: 8] = rx_data_in;
            end
            if (idx_q == 2'd3) begin
              bus_cnt_d = '0;
              if (state_q == S_ADDR && is_write_q) begin
                state_d = S_MASK;
              end else begin
                state_d = S_BUS;
                read_d  = !is_write_q;
                write_d = is_write_q;
              end
            end
          end
        end else if (frame_cnt_q == FW'(FRAME_TIMEOUT - 1)) begin
          state_d = S_IDLE;
        end else begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end
      S_BUS: begin
        if (rx_valid_in) overrun_d = 1'b1;
        // ready_in takes priority over a timeout expiring in the same cycle
        if (ready_in) begin
          read_d     = 1'b0;
          write_d    = 1'b0;
          state_d    = S_RESP;
          tx_valid_d = 1'b1;
          if (fault_in) begin
            tx_data_d = 8'h01;
            tx_left_d = '0;
          end else begin
            tx_data_d = 8'h00;
            tx_left_d = read_q ? 3'd4 : 3'd0;
            rdata_d   = read_value_in;
          end
        end else if (bus_cnt_q == BW'(BUS_TIMEOUT - 1)) begin
          read_d     = 1'b0;
          write_d    = 1'b0;
          state_d    = S_RESP;
          tx_valid_d = 1'b1;
          tx_data_d  = 8'h03;
          tx_left_d  = '0;
        end else begin
          bus_cnt_d = bus_cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rx_valid_in) overrun_d = 1'b1;
        if (tx_ready_in) begin
          if (tx_left_q == 3'd0) begin
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            tx_data_d = rdata_q[7:0];
            rdata_d   = {8'h00, rdata_q[31:8]};
            tx_left_d = tx_left_q - 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx_valid_out    = tx_valid_q;
  assign tx_data_out     = tx_data_q;
  assign address_out     = {addr_q, 2'b00};
  assign read_out        = read_q;
  assign write_out       = write_q;
  assign write_mask_out  = is_write_q ? mask_q : 4'h0;
  assign write_value_out = wdata_q;
  assign overrun_out     = overrun_q;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// tb/tb_uart_bus_bridge.sv - scoreboard bench for uart_bus_bridge with a frame-level reference model
// Stimulus pushes expected bus cycles and tx bytes; independent monitors pop and compare.
module tb_uart_bus_bridge;

  localparam int BT = 16;
  localparam int FT = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_valid_in = 1'b0;
  logic [7:0]  rx_data_in = 8'h00;
  logic        tx_valid_out;
  logic [7:0]  tx_data_out;
  logic        tx_ready_in;
  logic [31:0] address_out;
  logic        read_out;
  logic        write_out;
  logic [3:0]  write_mask_out;
  logic [31:0] write_value_out;
  logic [31:0] read_value_in;
  logic        ready_in;
  logic        fault_in;
  logic        overrun_out;

  uart_bus_bridge #(.BUS_TIMEOUT(BT), .FRAME_TIMEOUT(FT)) dut (
    .clk(clk), .reset(reset),
    .rx_valid_in(rx_valid_in), .rx_data_in(rx_data_in),
    .tx_valid_out(tx_valid_out), .tx_data_out(tx_data_out), .tx_ready_in(tx_ready_in),
    .address_out(address_out), .read_out(read_out), .write_out(write_out),
    .write_mask_out(write_mask_out), .write_value_out(write_value_out),
    .read_value_in(read_value_in), .ready_in(ready_in), .fault_in(fault_in),
    .overrun_out(overrun_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] val;
    int          len;
  } bus_t;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  tx_q[$];
  bus_t        bus_q[$];
  int          resp_delay = 0;
  logic        resp_fault = 1'b0;
  logic [31:0] resp_value = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // bus responder: ready_in after resp_delay request cycles (negative = never)
  initial begin
    int req_cnt;
    req_cnt = 0;
    ready_in = 1'b0;
    fault_in = 1'b0;
    read_value_in = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (read_out || write_out) begin
        if (resp_delay >= 0 && req_cnt == resp_delay) begin
          ready_in = 1'b1;
          fault_in = resp_fault;
          read_value_in = resp_value;
        end else begin
          ready_in = 1'b0;
          fault_in = 1'($urandom % 2);
          read_value_in = $urandom;
        end
        req_cnt++;
      end else begin
        ready_in = 1'b0;
        fault_in = 1'b0;
        req_cnt = 0;
      end
    end
  end

  initial begin
    tx_ready_in = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      tx_ready_in = ($urandom % 3) != 0;
    end
  end

  // tx monitor: compare each accepted byte, and hold stability while stalled
  initial begin
    bit         pend;
    logic [7:0] held;
    logic [7:0] e;
    pend = 0;
    held = 8'h00;
    forever begin
      @(negedge clk);
      if (pend) begin
        check("tx_valid_held", 32'(tx_valid_out), 32'd1);
        check("tx_data_held", 32'(tx_data_out), 32'(held));
      end
      if (tx_valid_out && tx_ready_in) begin
        if (tx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got byte %h with none expected", tx_data_out);
        end else begin
          e = tx_q.pop_front();
          check("tx_byte", 32'(tx_data_out), 32'(e));
        end
      end
      pend = tx_valid_out && !tx_ready_in;
      held = tx_data_out;
    end
  end

  // bus monitor: compare each request against the model, then its stability and hold length
  initial begin
    bit          in_req;
    int          hold;
    bus_t        cur;
    logic [31:0] a0, v0;
    logic [3:0]  m0;
    logic        w0;
    in_req = 0;
    hold = 0;
    cur.len = -1;
    forever begin
      @(negedge clk);
      if (read_out || write_out) begin
        check("bus_exclusive", 32'(read_out & write_out), 32'd0);
        if (!in_req) begin
          in_req = 1;
          hold = 1;
          a0 = address_out;
          v0 = write_value_out;
          m0 = write_mask_out;
          w0 = write_out;
          if (bus_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL bus_unexpected: request at %h with none expected", address_out);
            cur.len = -1;
          end else begin
            cur = bus_q.pop_front();
            check("bus_write", 32'(write_out), 32'(cur.wr));
            check("bus_addr", address_out, cur.addr);
            check("bus_mask", 32'(write_mask_out), 32'(cur.mask));
            if (cur.wr) check("bus_wdata", write_value_out, cur.val);
          end
        end else begin
          hold++;
          check("bus_addr_stable", address_out, a0);
          check("bus_wdata_stable", write_value_out, v0);
          check("bus_mask_stable", 32'(write_mask_out), 32'(m0));
          check("bus_kind_stable", 32'(write_out), 32'(w0));
        end
      end else if (in_req) begin
        in_req = 0;
        if (cur.len >= 0) check("bus_hold_len", hold, cur.len);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid_in = 1'b1;
    rx_data_in = b;
    @(posedge clk);
    #2;
    rx_valid_in = 1'b0;
  endtask

  function automatic int hold_len(input int delay);
    if (delay < 0 || delay >= BT) return BT;
    return delay + 1;
  endfunction

  task automatic push_status(input int delay, input logic fault);
    if (delay < 0 || delay >= BT) tx_q.push_back(8'h03);
    else if (fault) tx_q.push_back(8'h01);
    else tx_q.push_back(8'h00);
  endtask

  task automatic do_read(input logic [31:0] addr, input int delay, input logic fault,
                         input logic [31:0] val);
    bus_t e;
    resp_delay = delay;
    resp_fault = fault;
    resp_value = val;
    e.wr = 0;
    e.addr = {addr[31:2], 2'b00};
    e.mask = 4'h0;
    e.val = 32'h0;
    e.len = hold_len(delay);
    bus_q.push_back(e);
    push_status(delay, fault);
    if (delay >= 0 && delay < BT && !fault)
      for (int i = 0; i < 4; i++) tx_q.push_back(val[8*i +: 8]);
    send_byte(8'h52);
    for (int i = 0; i < 4; i++) begin
      idle($urandom_range(0, 3));
      send_byte(addr[8*i +: 8]);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] m, input logic [31:0] data,
                          input int delay, input logic fault, input int gap);
    bus_t e;
    resp_delay = delay;
    resp_fault = fault;
    resp_value = $urandom;
    e.wr = 1;
    e.addr = {addr[31:2], 2'b00};
    e.mask = m[3:0];
    e.val = data;
    e.len = hold_len(delay);
    bus_q.push_back(e);
    push_status(delay, fault);
    send_byte(8'h57);
    for (int i = 0; i < 4; i++) begin
      idle($urandom_range(0, 3));
      send_byte(addr[8*i +: 8]);
    end
    idle(gap);
    send_byte(m);
    for (int i = 0; i < 4; i++) begin
      idle($urandom_range(0, 3));
      send_byte(data[8*i +: 8]);
    end
  endtask

  task automatic do_bad(input logic [7:0] op);
    tx_q.push_back(8'h02);
    send_byte(op);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((tx_q.size() != 0 || bus_q.size() != 0 || read_out || write_out || tx_valid_out)
           && n < 1000) begin
      idle(1);
      n++;
    end
    check("drain_in_time", 32'(n < 1000), 32'd1);
    idle(2);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_valid"}, 32'(tx_valid_out), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data_out), 32'd0);
    check({tag, "_read"}, 32'(read_out), 32'd0);
    check({tag, "_write"}, 32'(write_out), 32'd0);
    check({tag, "_addr"}, address_out, 32'd0);
    check({tag, "_mask"}, 32'(write_mask_out), 32'd0);
    check({tag, "_wdata"}, write_value_out, 32'd0);
    check({tag, "_overrun"}, 32'(overrun_out), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    logic [7:0]  op;
    logic [31:0] a;
    int          kind;
    bus_t        e;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #2;
    reset = 1'b1;
    idle(2);

    do_write(32'h0000_0010, 8'h0F, 32'hDEAD_BEEF, 2, 1'b0, 0);
    wait_idle();
    do_read(32'h0000_0010, 1, 1'b0, 32'hDEAD_BEEF);
    wait_idle();
    do_read(32'h0200_0000, 0, 1'b1, 32'h1234_5678);
    wait_idle();
    do_bad(8'h41);
    wait_idle();
    do_read(32'h0000_0103, 3, 1'b0, 32'hCAFE_F00D);
    wait_idle();
    do_write(32'h0000_0044, 8'hA5, 32'h0BAD_F00D, 0, 1'b0, 0);
    wait_idle();
    do_read(32'h0000_0020, BT - 1, 1'b0, 32'h8765_4321);
    wait_idle();

    check("overrun_clear", 32'(overrun_out), 32'd0);
    do_read(32'h0000_0080, -1, 1'b0, 32'h0);
    idle(3);
    send_byte(8'h55);
    send_byte(8'hAA);
    wait_idle();
    check("overrun_set", 32'(overrun_out), 32'd1);
    do_bad(8'hFF);
    wait_idle();
    check("overrun_kept_bad_op", 32'(overrun_out), 32'd1);
    do_read(32'h0000_0084, 1, 1'b0, 32'h0102_0304);
    wait_idle();
    check("overrun_cleared_by_r", 32'(overrun_out), 32'd0);

    send_byte(8'h57);
    send_byte(8'h10);
    send_byte(8'h00);
    idle(FT + 6);
    check("frame_timeout_no_tx", 32'(tx_valid_out), 32'd0);
    do_read(32'h0000_0010, 2, 1'b0, 32'h5566_7788);
    wait_idle();
    do_write(32'h0000_0200, 8'h03, 32'h1357_9BDF, 1, 1'b0, FT - 20);
    wait_idle();

    for (int it = 0; it < 10; it++) begin
      kind = $urandom % 5;
      a = $urandom;
      if (kind < 2) begin
        do_read(a, $urandom_range(0, 4), ($urandom % 4) == 0, $urandom);
      end else if (kind < 4) begin
        do_write(a, 8'($urandom), $urandom, $urandom_range(0, 4), ($urandom % 4) == 0, 0);
      end else begin
        op = 8'($urandom);
        while (op == 8'h52 || op == 8'h57) op = 8'($urandom);
        do_bad(op);
      end
      wait_idle();
    end

    resp_delay = -1;
    e.wr = 0;
    e.addr = 32'h0000_0300;
    e.mask = 4'h0;
    e.val = 32'h0;
    e.len = -1;
    bus_q.push_back(e);
    send_byte(8'h52);
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h00);
    idle(4);
    check("pre_reset_read", 32'(read_out), 32'd1);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("mid_bus_reset");
    @(posedge clk);
    #2;
    reset = 1'b1;
    idle(2);
    do_read(32'h0000_0010, 0, 1'b0, 32'hA5A5_5A5A);
    wait_idle();

    check("tx_queue_empty", 32'(tx_q.size()), 32'd0);
    check("bus_queue_empty", 32'(bus_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
